// File: rtl/simplez_loader.sv
// Serial program loader for Simplez: framed UART image -> 512x12 RAM.
// Holds the CPU in reset while it owns the RAM write port.
module simplez_loader #(
  parameter int unsigned TIMEOUT = 12_000_000,
  parameter bit          AUTORUN = 1'b1,
  parameter logic [7:0]  HEADER  = 8'h4C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rcv,
  output logic [8:0] mem_addr,
  output logic [11:0] mem_din,
  output logic       mem_we,
  output logic       cpu_rstn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [8:0] NMAX = 9'd504;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_CHK
  } state_t;

  localparam state_t S_RST = AUTORUN ? S_RUN : S_IDLE;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]  idx_q, idx_d;
  logic [8:0]  n_q, n_d;
  logic        cnt_hi_q, cnt_hi_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  sum_q, sum_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [11:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_rstn_q, cpu_rstn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic       in_frame;
  logic       tmo;
  logic       hdr;
  logic       last;
  logic [8:0] n_rx;

  assign in_frame = (state_q != S_IDLE) && (state_q != S_RUN);
  assign tmo      = in_frame && !rx_rcv && (timer_q == TMAX);
  assign hdr      = rx_rcv && !in_frame && (rx_data == HEADER);
  assign n_rx     = {cnt_hi_q, rx_data};
  assign last     = (idx_q + 9'd1) == n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      timer_q    <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      cnt_hi_q   <= 1'b0;
      hi_q       <= '0;
      sum_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      cpu_rstn_q <= AUTORUN;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      cnt_hi_q   <= cnt_hi_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = S_IDLE;
    end else if (rx_rcv) begin
      unique case (state_q)
        S_IDLE, S_RUN: if (rx_data == HEADER) state_d = S_CNT_H;
        S_CNT_H: state_d = S_CNT_L;
        S_CNT_L: begin
          if (n_rx > NMAX)     state_d = S_IDLE;
          else if (n_rx == '0) state_d = S_CHK;
          else                 state_d = S_DATA_H;
        end
        S_DATA_H: state_d = S_DATA_L;
        S_DATA_L: state_d = last ? S_CHK : S_DATA_H;
        S_CHK:    state_d = (rx_data == sum_q) ? S_RUN : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_d    = (!in_frame || rx_rcv) ? '0 : timer_q + TW'(1);
    idx_d      = idx_q;
    n_d        = n_q;
    cnt_hi_d   = cnt_hi_q;
    hi_d       = hi_q;
    sum_d      = sum_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    cpu_rstn_d = cpu_rstn_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    if (hdr) begin
      cpu_rstn_d = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      sum_d      = '0;
      idx_d      = '0;
    end
    if (rx_rcv && in_frame) begin
      if (state_q != S_CHK) sum_d = sum_q ^ rx_data;
      unique case (state_q)
        S_CNT_H:  cnt_hi_d = rx_data[0];
        S_CNT_L:  n_d = n_rx;
        S_DATA_H: hi_d = rx_data[3:0];
        S_DATA_L: begin
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q;
          mem_din_d  = {hi_q, rx_data};
          idx_d      = idx_q + 9'd1;
        end
        default: ;
      endcase
    end
    // any in-frame fall back to IDLE is an abort; CPU stays held
    if (in_frame && state_d == S_IDLE) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
    if (state_q == S_CHK && state_d == S_RUN) begin
      done_d     = 1'b1;
      cpu_rstn_d = 1'b1;
      busy_d     = 1'b0;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign cpu_rstn = cpu_rstn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_simplez_loader.sv
// Directed bench for simplez_loader: frames, aborts,
// timeout boundary, restart from RUN and mid-frame reset.
module tb_simplez_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_rcv = 1'b0;
  logic [8:0] mem_addr;
  logic [11:0] mem_din;
  logic       mem_we;
  logic       cpu_rstn;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] rx_data2 = '0;
  logic       rx_rcv2 = 1'b0;
  logic [8:0] mem_addr2;
  logic [11:0] mem_din2;
  logic       mem_we2;
  logic       cpu_rstn2;
  logic       busy2;
  logic       done2;
  logic       err2;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int wr_viol = 0;
  int snap;

  always #5 clk = ~clk;

  simplez_loader #(
    .TIMEOUT(16), .AUTORUN(1'b1), .HEADER(8'h4C)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_rcv(rx_rcv),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );

  simplez_loader #(
    .TIMEOUT(16), .AUTORUN(1'b0), .HEADER(8'h4C)
  ) dut_noauto (
    .clk(clk), .rst(rst),
    .rx_data(rx_data2), .rx_rcv(rx_rcv2),
    .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_we(mem_we2),
    .cpu_rstn(cpu_rstn2), .busy(busy2), .done(done2), .err(err2)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt = wr_cnt + 1;
      if (cpu_rstn) wr_viol = wr_viol + 1;
    end
  end

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // caller sits at a negedge; returns at the negedge after the sampling edge
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rcv  = 1'b1;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic good_frame(input string tag);
    send(8'h4C);
    expect_eq({tag, "_hdr_rstn"}, cpu_rstn, 0);
    expect_eq({tag, "_hdr_busy"}, busy, 1);
    expect_eq({tag, "_hdr_err"}, err, 0);
    send(8'h00);
    send(8'h02);
    send(8'h0A);
    send(8'h05);
    expect_eq({tag, "_w0_we"}, mem_we, 1);
    expect_eq({tag, "_w0_addr"}, mem_addr, 9'h000);
    expect_eq({tag, "_w0_din"}, mem_din, 12'hA05);
    send(8'h03);
    expect_eq({tag, "_w0_we_off"}, mem_we, 0);
    send(8'hFF);
    expect_eq({tag, "_w1_we"}, mem_we, 1);
    expect_eq({tag, "_w1_addr"}, mem_addr, 9'h001);
    expect_eq({tag, "_w1_din"}, mem_din, 12'h3FF);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    expect_eq("rst_rstn", cpu_rstn, 1);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_err", err, 0);
    expect_eq("rst_we", mem_we, 0);
    expect_eq("rst_addr", mem_addr, 0);
    expect_eq("rst_din", mem_din, 0);
    expect_eq("rst_noauto_rstn", cpu_rstn2, 0);
    expect_eq("rst_noauto_busy", busy2, 0);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("post_rst_rstn", cpu_rstn, 1);
    expect_eq("post_rst_noauto", cpu_rstn2, 0);

    // 00^02^0A^05^03^FF = F1 (count bytes included)
    snap = wr_cnt;
    good_frame("good");
    send(8'hF1);
    expect_eq("good_done", done, 1);
    expect_eq("good_rstn", cpu_rstn, 1);
    expect_eq("good_err", err, 0);
    expect_eq("good_busy", busy, 0);
    expect_eq("good_addr_hold", mem_addr, 9'h001);
    expect_eq("good_writes", wr_cnt - snap, 2);

    snap = wr_cnt;
    good_frame("badchk");
    send(8'h00);
    expect_eq("badchk_err", err, 1);
    expect_eq("badchk_done", done, 0);
    expect_eq("badchk_rstn", cpu_rstn, 0);
    expect_eq("badchk_busy", busy, 0);
    expect_eq("badchk_writes", wr_cnt - snap, 2);
    idle(3);
    expect_eq("badchk_err_sticky", err, 1);

    good_frame("again");
    send(8'hF1);
    expect_eq("again_err", err, 0);
    expect_eq("again_done", done, 1);

    snap = wr_cnt;
    send(8'h4C);
    send(8'h01);
    send(8'hF9);
    expect_eq("n505_err", err, 1);
    expect_eq("n505_busy", busy, 0);
    expect_eq("n505_rstn", cpu_rstn, 0);
    idle(2);
    expect_eq("n505_writes", wr_cnt - snap, 0);

    send(8'h4C);
    send(8'h01);
    send(8'hF8);
    expect_eq("n504_err", err, 0);
    expect_eq("n504_busy", busy, 1);
    idle(17);
    expect_eq("n504_tmo_err", err, 1);

    snap = wr_cnt;
    send(8'h4C);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    expect_eq("n0_done", done, 1);
    expect_eq("n0_rstn", cpu_rstn, 1);
    expect_eq("n0_err", err, 0);
    idle(2);
    expect_eq("n0_writes", wr_cnt - snap, 0);

    snap = wr_cnt;
    send(8'h4C);
    send(8'h00);
    send(8'h01);
    send(8'h0A);
    idle(15);
    expect_eq("tmo_early", err, 0);
    expect_eq("tmo_early_busy", busy, 1);
    @(negedge clk);
    expect_eq("tmo_err", err, 1);
    expect_eq("tmo_busy", busy, 0);
    expect_eq("tmo_writes", wr_cnt - snap, 0);

    snap = wr_cnt;
    send(8'h4C);
    send(8'h00);
    send(8'h01);
    send(8'h0A);
    idle(15);
    send(8'h05);
    expect_eq("alive_err", err, 0);
    expect_eq("alive_we", mem_we, 1);
    expect_eq("alive_din", mem_din, 12'hA05);
    send(8'h0E);
    expect_eq("alive_done", done, 1);
    expect_eq("alive_writes", wr_cnt - snap, 1);

    send(8'h41);
    expect_eq("run_ign_rstn", cpu_rstn, 1);
    expect_eq("run_ign_busy", busy, 0);
    send(8'h4C);
    expect_eq("run_hdr_rstn", cpu_rstn, 0);
    expect_eq("run_hdr_done", done, 0);
    send(8'h00);
    send(8'h02);
    send(8'h0A);
    snap = wr_cnt;
    rst = 1'b1;
    rx_data = 8'h05;
    rx_rcv = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_rcv = 1'b0;
    expect_eq("midrst_we", mem_we, 0);
    expect_eq("midrst_rstn", cpu_rstn, 1);
    expect_eq("midrst_busy", busy, 0);
    expect_eq("midrst_addr", mem_addr, 0);
    expect_eq("midrst_din", mem_din, 0);
    send(8'hFF);
    idle(2);
    expect_eq("midrst_writes", wr_cnt - snap, 0);

    expect_eq("we_while_run", wr_viol, 0);
    expect_eq("noauto_idle_we", mem_we2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
